// File: rtl/registrador_de_instrucao.sv
// registrador_de_instrucao: instruction buffer in front of the bit extender.
// Queues 32-bit instruction words in a small FIFO and decodes the head entry
// into opcode, extend select and the 14/23-bit immediates.
// Optional feature macro: CONTADOR_INSTR_EN adds a 32-bit retired-pop counter.
module registrador_de_instrucao #(
  parameter int         PROFUNDIDADE  = 2,
  parameter logic [4:0] OPCODE_J_BASE = 5'h18
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic        ready_out,
  output logic        valid_out,
  output logic [4:0]  opcode,
  output logic        controle,
  output logic [13:0] tamanho14,
  output logic [22:0] tamanho23
`ifdef CONTADOR_INSTR_EN
  ,
  output logic [31:0] contador_instr
`endif
);

  localparam int PTR_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int CNT_W = $clog2(PROFUNDIDADE) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(PROFUNDIDADE);

  logic [31:0]      r_mem [PROFUNDIDADE];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head;
  logic [31:0]      w_head_vis;

  // Handshake qualifiers; ready_in depends on the stored count only, so the
  // upstream never sees a combinational path from ready_out.
  assign ready_in  = (r_count != FULL_COUNT);
  assign valid_out = (r_count != '0);
  assign w_push    = valid_in && ready_in;
  assign w_pop     = valid_out && ready_out;

  // Pointer and occupancy update; flush overrides any same-cycle push/pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Word storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= instr_in;
    end
  end

  // Head decode; every field reads as zero while the queue is empty.
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_vis = valid_out ? w_head : 32'h0;
  assign opcode     = w_head_vis[31:27];
  assign controle   = valid_out && (w_head_vis[31:27] >= OPCODE_J_BASE);
  assign tamanho14  = w_head_vis[13:0];
  assign tamanho23  = w_head_vis[22:0];

`ifdef CONTADOR_INSTR_EN
  logic [31:0] r_contador_instr;

  // Counts consumed words; survives flush, and a pop cancelled by flush is not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_contador_instr <= 32'h0;
    end else if (w_pop && !flush) begin
      r_contador_instr <= r_contador_instr + 32'h1;
    end
  end

  assign contador_instr = r_contador_instr;
`endif

endmodule
